// File: rtl/l2_frame_tracker.sv
// Passive RX AXI-Stream monitor: byte-accurate frame position, VLAN tag-chain walk to the true
// L2 header length, final EtherType, frame length and runt reporting. Define ETHERPARSE_QINQ_EN to add 0x88A8/0x9100 as TPIDs.
module l2_frame_tracker #(
   parameter int DATA_WIDTH    = 64,
   parameter int CNT_WIDTH     = 16,
   parameter int MAX_VLAN_TAGS = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_tvalid,
   input  logic                    s_tready,
   input  logic [DATA_WIDTH-1:0]   s_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_tkeep,
   input  logic                    s_tlast,
   output logic [CNT_WIDTH-1:0]    byte_count,
   output logic [5:0]              hdr_len,
   output logic [2:0]              vlan_count,
   output logic [15:0]             ethertype,
   output logic                    ethertype_valid,
   output logic                    in_l2_header,
   output logic                    header_done,
   output logic                    sof,
   output logic                    frame_done,
   output logic [CNT_WIDTH-1:0]    frame_len,
   output logic                    len_sat,
   output logic                    hdr_err
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int OW = CNT_WIDTH + 8;
   localparam logic [OW-1:0] CNT_MAX = (OW'(1) << CNT_WIDTH) - OW'(1);

   typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   bc_q, bc_d;
   logic [CNT_WIDTH-1:0]   fl_q;
   logic                   sat_q, sat_d;
   logic [5:0]             p_q, p_d;
   logic [5:0]             hl_q, hl_d;
   logic [2:0]             vc_q, vc_d;
   logic [15:0]            et_q, et_d;
   logic                   etv_q, etv_d;
   logic [7:0]             hi_q, hi_d;
   logic                   hiv_q, hiv_d;
   logic                   sof_q, fd_q, herr_q, hdend_q;

   logic                   acc;
   logic                   first;
   logic                   ovf;
   logic                   hdr_cmpl;
   logic [CNT_WIDTH-1:0]   base_cnt;
   logic [OW-1:0]          base_ext;
   logic [CNT_WIDTH:0]     sum_w;

   function automatic logic [OW-1:0] popcount(input logic [NB-1:0] keep);
      logic [OW-1:0] n;
      n = '0;
      for (int l = 0; l < NB; l++) n = n + OW'(keep[l]);
      return n;
   endfunction

   function automatic logic [CNT_WIDTH:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                  input logic [OW-1:0]        b);
      logic [OW-1:0] s;
      s = OW'(a) + b;
      if (s > CNT_MAX) return {1'b1, CNT_MAX[CNT_WIDTH-1:0]};
      return {1'b0, s[CNT_WIDTH-1:0]};
   endfunction

   // Returns {hit, byte} for absolute frame offset off within the current beat.
   function automatic logic [8:0] pick_byte(input logic [OW-1:0]         base,
                                            input logic [OW-1:0]         off,
                                            input logic [NB-1:0]         keep,
                                            input logic [DATA_WIDTH-1:0] data);
      logic [8:0] r;
      r = '0;
      for (int l = 0; l < NB; l++) begin
         if (keep[l] && ((base + OW'(l)) == off)) r = {1'b1, data[8*l +: 8]};
      end
      return r;
   endfunction

   function automatic logic is_tpid(input logic [15:0] v);
`ifdef ETHERPARSE_QINQ_EN
      return (v == 16'h8100) || (v == 16'h88A8) || (v == 16'h9100);
`else
      return v == 16'h8100;
`endif
   endfunction

   assign acc      = s_tvalid & s_tready;
   assign first    = (state_q == IDLE);
   assign base_cnt = first ? '0 : bc_q;
   assign base_ext = OW'(base_cnt);
   assign sum_w    = sat_add(base_cnt, popcount(s_tkeep));
   assign ovf      = sum_w[CNT_WIDTH];
   assign bc_d     = sum_w[CNT_WIDTH-1:0];
   assign sat_d    = (first ? 1'b0 : sat_q) | ovf;

   // Tag-chain walk, one unrolled stage per possible tag plus the final EtherType.
   always_comb begin : chain
      logic [8:0]  hb9;
      logic [8:0]  lb9;
      logic [15:0] tv;
      p_d   = first ? 6'd12 : p_q;
      hl_d  = first ? 6'd14 : hl_q;
      vc_d  = first ? 3'd0  : vc_q;
      et_d  = first ? 16'd0 : et_q;
      etv_d = first ? 1'b0  : etv_q;
      hi_d  = first ? 8'd0  : hi_q;
      hiv_d = first ? 1'b0  : hiv_q;
      hb9   = '0;
      lb9   = '0;
      tv    = '0;
      for (int k = 0; k <= MAX_VLAN_TAGS; k++) begin
         if (!etv_d) begin
            hb9 = hiv_d ? {1'b1, hi_d} : pick_byte(base_ext, OW'(p_d), s_tkeep, s_tdata);
            lb9 = pick_byte(base_ext, OW'(p_d) + OW'(1), s_tkeep, s_tdata);
            tv  = {hb9[7:0], lb9[7:0]};
            if (hb9[8] && lb9[8]) begin
               if (is_tpid(tv) && (int'(vc_d) < MAX_VLAN_TAGS)) begin
                  vc_d = vc_d + 3'd1;
                  p_d  = p_d + 6'd4;
                  hl_d = hl_d + 6'd4;
               end else begin
                  et_d  = tv;
                  etv_d = 1'b1;
               end
               hiv_d = 1'b0;
            end else if (hb9[8]) begin
               hi_d  = hb9[7:0];
               hiv_d = 1'b1;
            end
         end
      end
   end

   assign hdr_cmpl = etv_d && (OW'(bc_d) >= OW'(hl_d));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (acc) begin
         if (s_tlast)       state_d = IDLE;
         else if (hdr_cmpl) state_d = BODY;
         else               state_d = HDR;
      end
   end

   always_comb begin
      in_l2_header = (state_q == HDR);
      header_done  = (state_q == BODY) | hdend_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bc_q    <= '0;
         fl_q    <= '0;
         sat_q   <= 1'b0;
         p_q     <= '0;
         hl_q    <= '0;
         vc_q    <= '0;
         et_q    <= '0;
         etv_q   <= 1'b0;
         hi_q    <= '0;
         hiv_q   <= 1'b0;
         sof_q   <= 1'b0;
         fd_q    <= 1'b0;
         herr_q  <= 1'b0;
         hdend_q <= 1'b0;
      end else begin
         sof_q  <= acc & first;
         fd_q   <= acc & s_tlast;
         herr_q <= acc & s_tlast & ~hdr_cmpl;
         if (acc) begin
            bc_q    <= bc_d;
            sat_q   <= sat_d;
            p_q     <= p_d;
            hl_q    <= hl_d;
            vc_q    <= vc_d;
            et_q    <= et_d;
            etv_q   <= etv_d;
            hi_q    <= hi_d;
            hiv_q   <= hiv_d;
            hdend_q <= s_tlast & hdr_cmpl;
            if (s_tlast) fl_q <= bc_d;
         end
      end
   end

   assign byte_count      = bc_q;
   assign hdr_len         = hl_q;
   assign vlan_count      = vc_q;
   assign ethertype       = et_q;
   assign ethertype_valid = etv_q;
   assign sof             = sof_q;
   assign frame_done      = fd_q;
   assign frame_len       = fl_q;
   assign len_sat         = sat_q;
   assign hdr_err         = herr_q;

endmodule

// File: tb/tb_l2_frame_tracker.sv
// Scoreboard bench for l2_frame_tracker: directed frames, per-beat expectations checked by a monitor.
module tb_l2_frame_tracker;
   localparam int DW = 64;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_tvalid = 1'b0;
   logic          s_tready = 1'b0;
   logic          s_tlast = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic [NB-1:0] s_tkeep = '0;

   logic [15:0] a_bc, a_fl, a_et;
   logic [5:0]  a_hl;
   logic [2:0]  a_vc;
   logic        a_etv, a_inh, a_hd, a_sof, a_fd, a_sat, a_herr;
   logic [7:0]  b_bc, b_fl;
   logic [15:0] b_et;
   logic [5:0]  b_hl;
   logic [2:0]  b_vc;
   logic        b_etv, b_inh, b_hd, b_sof, b_fd, b_sat, b_herr;

   always #5 clk = ~clk;

   l2_frame_tracker #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .MAX_VLAN_TAGS(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .byte_count(a_bc), .hdr_len(a_hl), .vlan_count(a_vc),
      .ethertype(a_et), .ethertype_valid(a_etv), .in_l2_header(a_inh), .header_done(a_hd),
      .sof(a_sof), .frame_done(a_fd), .frame_len(a_fl), .len_sat(a_sat), .hdr_err(a_herr));

   l2_frame_tracker #(.DATA_WIDTH(DW), .CNT_WIDTH(8), .MAX_VLAN_TAGS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .byte_count(b_bc), .hdr_len(b_hl), .vlan_count(b_vc),
      .ethertype(b_et), .ethertype_valid(b_etv), .in_l2_header(b_inh), .header_done(b_hd),
      .sof(b_sof), .frame_done(b_fd), .frame_len(b_fl), .len_sat(b_sat), .hdr_err(b_herr));

   typedef struct {
      int          fid;
      int          beat;
      logic [15:0] bc;
      logic        sof, fd, herr, hd, inh;
      logic        chk_hdr, chk_len;
      logic [15:0] et;
      logic        etv;
      logic [5:0]  hl;
      logic [2:0]  vc;
      logic [15:0] fl;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] fr [0:511];
   int         n_chk = 0;
   int         n_err = 0;
   logic       acc_seen = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: one expectation per accepted beat, compared half a cycle later.
   always @(posedge clk) acc_seen <= s_tvalid & s_tready & rst_n;

   always @(negedge clk) begin
      if (acc_seen) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("f%0d.b%0d byte_count", mon_e.fid, mon_e.beat), a_bc, mon_e.bc);
            chk($sformatf("f%0d.b%0d sof", mon_e.fid, mon_e.beat), a_sof, mon_e.sof);
            chk($sformatf("f%0d.b%0d frame_done", mon_e.fid, mon_e.beat), a_fd, mon_e.fd);
            chk($sformatf("f%0d.b%0d hdr_err", mon_e.fid, mon_e.beat), a_herr, mon_e.herr);
            chk($sformatf("f%0d.b%0d header_done", mon_e.fid, mon_e.beat), a_hd, mon_e.hd);
            chk($sformatf("f%0d.b%0d in_l2_header", mon_e.fid, mon_e.beat), a_inh, mon_e.inh);
            chk($sformatf("f%0d.b%0d len_sat", mon_e.fid, mon_e.beat), a_sat, 64'd0);
            if (mon_e.chk_hdr) begin
               chk($sformatf("f%0d.b%0d ethertype", mon_e.fid, mon_e.beat), a_et, mon_e.et);
               chk($sformatf("f%0d.b%0d ethertype_valid", mon_e.fid, mon_e.beat), a_etv, mon_e.etv);
               chk($sformatf("f%0d.b%0d hdr_len", mon_e.fid, mon_e.beat), a_hl, mon_e.hl);
               chk($sformatf("f%0d.b%0d vlan_count", mon_e.fid, mon_e.beat), a_vc, mon_e.vc);
            end
            if (mon_e.chk_len)
               chk($sformatf("f%0d.b%0d frame_len", mon_e.fid, mon_e.beat), a_fl, mon_e.fl);
         end
      end
   end

   task automatic init_frame();
      for (int i = 0; i < 512; i++) fr[i] = 8'(i * 7 + 3);
      fr[12] = 8'h08;
      fr[13] = 8'h00;
   endtask

   task automatic set16(input int off, input logic [15:0] v);
      fr[off]     = v[15:8];
      fr[off + 1] = v[7:0];
   endtask

   task automatic idle(input int n);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // hd_beat: index of the beat after which header_done is expected (>= nbeats: never).
   // cut > 0 sends only that many beats without tlast.
   task automatic send_frame(input int fid, input int nbeats, input int cut,
                             input logic [NB-1:0] first_keep, input logic [NB-1:0] last_keep,
                             input int hd_beat, input logic [15:0] et, input logic etv,
                             input logic [5:0] hl, input logic [2:0] vc, input int stall_at);
      int            base;
      int            nsend;
      logic [NB-1:0] k;
      logic          last;
      exp_t          e;
      base  = 0;
      nsend = (cut > 0) ? cut : nbeats;
      for (int i = 0; i < nsend; i++) begin
         k    = (i == 0) ? first_keep : ((i == nbeats - 1) ? last_keep : '1);
         last = (cut == 0) && (i == nbeats - 1);
         for (int l = 0; l < NB; l++) s_tdata[8*l +: 8] = fr[base + l];
         s_tkeep  = k;
         s_tlast  = last;
         s_tvalid = 1'b1;
         s_tready = 1'b1;
         for (int l = 0; l < NB; l++) base += int'(k[l]);
         e.fid     = fid;
         e.beat    = i;
         e.bc      = 16'(base);
         e.sof     = (i == 0);
         e.fd      = last;
         e.herr    = last && (hd_beat >= nbeats);
         e.hd      = (i >= hd_beat);
         e.inh     = !last && (i < hd_beat);
         e.chk_hdr = (i >= hd_beat) || last;
         e.chk_len = last;
         e.et      = et;
         e.etv     = etv;
         e.hl      = hl;
         e.vc      = vc;
         e.fl      = 16'(base);
         sb.push_back(e);
         @(posedge clk);
         #1;
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
         if (i == stall_at) begin
            s_tvalid = 1'b1;
            s_tready = 1'b0;
            repeat (3) begin
               @(posedge clk);
               #1;
               chk($sformatf("f%0d stall byte_count", fid), a_bc, 64'(base));
            end
            s_tvalid = 1'b0;
            s_tready = 1'b1;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " counts"}, {a_bc, a_fl, b_bc, b_fl}, 64'd0);
      chk({tag, " hdr"}, {a_hl, a_vc, a_et, a_etv}, 64'd0);
      chk({tag, " flags"}, {a_inh, a_hd, a_sof, a_fd, a_sat, a_herr, b_sat, b_hd}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      idle(1);

      // Untagged 64-byte frame
      init_frame();
      send_frame(1, 8, 0, 8'hFF, 8'hFF, 1, 16'h0800, 1'b1, 6'd14, 3'd0, -1);
      idle(2);
      chk("b frame_len 64", b_fl, 64'd64);
      chk("b len_sat clear", b_sat, 64'd0);

      // Single 0x8100 tag then 0x86DD, with a 3-cycle stall after beat 1
      init_frame();
      set16(12, 16'h8100); set16(14, 16'h0005); set16(16, 16'h86DD);
      send_frame(2, 8, 0, 8'hFF, 8'hFF, 2, 16'h86DD, 1'b1, 6'd18, 3'd1, 1);
      idle(2);

      // 0x88A8 / 0x8100 / 0x0800
      init_frame();
      set16(12, 16'h88A8); set16(14, 16'h0064); set16(16, 16'h8100);
      set16(18, 16'h00C8); set16(20, 16'h0800);
`ifdef ETHERPARSE_QINQ_EN
      send_frame(3, 8, 0, 8'hFF, 8'hFF, 2, 16'h0800, 1'b1, 6'd22, 3'd2, -1);
`else
      send_frame(3, 8, 0, 8'hFF, 8'hFF, 1, 16'h88A8, 1'b1, 6'd14, 3'd0, -1);
`endif
      idle(2);

      // Three stacked tags: the third is reported as the EtherType
      init_frame();
      set16(12, 16'h8100); set16(16, 16'h8100); set16(20, 16'h8100);
      send_frame(4, 8, 0, 8'hFF, 8'hFF, 2, 16'h8100, 1'b1, 6'd22, 3'd2, -1);
      idle(2);

      // Short first beat: type field split across beats 1 and 2
      init_frame();
      send_frame(5, 4, 0, 8'h1F, 8'hFF, 2, 16'h0800, 1'b1, 6'd14, 3'd0, -1);
      idle(2);

      // Runt: 12 bytes
      init_frame();
      send_frame(6, 2, 0, 8'hFF, 8'h0F, 99, 16'h0000, 1'b0, 6'd14, 3'd0, -1);
      idle(2);

      // Single-beat frame
      init_frame();
      send_frame(7, 1, 0, 8'hFF, 8'hFF, 99, 16'h0000, 1'b0, 6'd14, 3'd0, -1);
      idle(2);

      // Reset mid-frame, then a fresh frame
      init_frame();
      send_frame(8, 8, 3, 8'hFF, 8'hFF, 1, 16'h0800, 1'b1, 6'd14, 3'd0, -1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(9, 8, 0, 8'hFF, 8'hFF, 1, 16'h0800, 1'b1, 6'd14, 3'd0, -1);
      idle(2);

      // 320 bytes: saturates the 8-bit counter instance only
      init_frame();
      send_frame(10, 40, 0, 8'hFF, 8'hFF, 1, 16'h0800, 1'b1, 6'd14, 3'd0, -1);
      idle(2);
      chk("b sat byte_count", b_bc, 64'd255);
      chk("b sat len_sat", b_sat, 64'd1);
      chk("b sat frame_len", b_fl, 64'd255);

      idle(3);
      chk("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
